// File: rtl/cache_refill_ctrl.sv
//==============================================================================
// Module   : cache_refill_ctrl
// Brief    : 4-line x 4-word direct-mapped cache controller with line refill on
//            load miss and write-through/no-write-allocate stores.
//            Define CACHE_STATS_EN to add saturating hit/miss counters.
// Revision : 1.0
//==============================================================================
`default_nettype none

module cache_refill_ctrl #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              hit,
    input  logic              miss,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [1:0]        lineid_in,
    input  logic [1:0]        wordid_in,
    output logic [TAG_W-1:0]  tag_ctrl [3:0],
    output logic              valid_ctrl [3:0],
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t              r_state;
    logic [TAG_W-1:0]    r_tag   [3:0];
    logic                r_valid [3:0];
    logic [DATA_W-1:0]   r_data  [4][4];
    logic [TAG_W-1:0]    r_req_tag;
    logic [1:0]          r_req_line;
    logic [1:0]          r_req_word;
    logic [1:0]          r_k;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_mem_req_valid;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic w_accept;
    logic w_hit;
    logic w_ld_hit;
    logic w_ld_miss;
    logic w_st;
    logic w_refill_beat;

    // A lookup that reports neither hit nor miss is treated as a miss.
    assign w_hit         = hit & ~miss;
    assign w_accept      = req_valid & (r_state == S_IDLE);
    assign w_ld_hit      = w_accept & ~req_we & w_hit;
    assign w_ld_miss     = w_accept & ~req_we & ~w_hit;
    assign w_st          = w_accept & req_we;
    assign w_refill_beat = (r_state == S_RD_WAIT) & mem_resp_valid;

    assign req_ready     = (r_state == S_IDLE);
    assign tag_ctrl      = r_tag;
    assign valid_ctrl    = r_valid;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_tag[i]   <= '0;
                r_valid[i] <= 1'b0;
            end
            r_req_tag       <= '0;
            r_req_line      <= '0;
            r_req_word      <= '0;
            r_k             <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_tag  <= tag_in;
                        r_req_line <= lineid_in;
                        r_req_word <= wordid_in;
                    end
                    if (w_ld_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_data[lineid_in][wordid_in];
                    end else if (w_ld_miss) begin
                        r_valid[lineid_in] <= 1'b0;
                        r_k                <= 2'd0;
                        r_mem_req_valid    <= 1'b1;
                        r_mem_we           <= 1'b0;
                        r_mem_addr         <= {tag_in, lineid_in, 2'd0};
                        r_state            <= S_RD_REQ;
                    end else if (w_st) begin
                        r_mem_req_valid <= 1'b1;
                        r_mem_we        <= 1'b1;
                        r_mem_addr      <= {tag_in, lineid_in, wordid_in};
                        r_mem_wdata     <= req_wdata;
                        r_state         <= S_WR_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_resp_valid) begin
                        if (r_k != 2'd3) begin
                            r_k             <= r_k + 2'd1;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= {r_req_tag, r_req_line, r_k + 2'd1};
                            r_state         <= S_RD_REQ;
                        end else begin
                            r_tag[r_req_line]   <= r_req_tag;
                            r_valid[r_req_line] <= 1'b1;
                            r_resp_valid        <= 1'b1;
                            // The last beat lands in the array on this same edge.
                            r_resp_rdata        <= (r_req_word == 2'd3) ? mem_resp_data
                                                   : r_data[r_req_line][r_req_word];
                            r_state             <= S_RESP;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_mem_we        <= 1'b0;
                        r_resp_valid    <= 1'b1;
                        r_resp_rdata    <= '0;
                        r_state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Data array deliberately has no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (w_st && w_hit) begin
            r_data[lineid_in][wordid_in] <= req_wdata;
        end
        if (w_refill_beat) begin
            r_data[r_req_line][r_k] <= mem_resp_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_ld_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_ld_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
//==============================================================================
// Module   : tb_cache_refill_ctrl
// Brief    : Scoreboard bench for cache_refill_ctrl with a lookup-stage model
//            and a stalling memory model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_wdata;
    logic        hit;
    logic        miss;
    logic [27:0] tag_in;
    logic [1:0]  lineid_in;
    logic [1:0]  wordid_in;
    logic [27:0] tag_ctrl [3:0];
    logic        valid_ctrl [3:0];
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    cache_refill_ctrl #(.DATA_W(32), .TAG_W(28)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wdata(req_wdata), .hit(hit), .miss(miss), .tag_in(tag_in),
        .lineid_in(lineid_in), .wordid_in(wordid_in),
        .tag_ctrl(tag_ctrl), .valid_ctrl(valid_ctrl),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Lookup stage: compares the request against the controller's tag/valid view.
    assign hit  = valid_ctrl[lineid_in] && (tag_ctrl[lineid_in] == tag_in);
    assign miss = ~hit;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    mem_op_t     exp_mem_q [$];
    logic [31:0] exp_resp_q [$];
    int          checks = 0;
    int          errors = 0;

    logic        m_valid [4];
    logic [27:0] m_tag   [4];
    logic [31:0] m_data  [4][4];
    logic [31:0] mem_w   [logic [31:0]];
    int          m_hits   = 0;
    int          m_misses = 0;
    int          mem_stall = 0;
    int          park_k    = -1;
    bit          parked    = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_w.exists(a)) return mem_w[a];
        if (a[31:4] == 28'h0000123) return 32'hA0 + {30'd0, a[1:0]};
        return {a[15:0], 16'h5A00} ^ 32'h00C3_0000;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_hits   = 0;
        m_misses = 0;
        exp_mem_q.delete();
        exp_resp_q.delete();
    endfunction

    // Reference model: queues the memory traffic and response a request must produce.
    function automatic void predict(input logic we, input logic [27:0] t,
                                    input logic [1:0] l, input logic [1:0] w,
                                    input logic [31:0] wd);
        logic [31:0] a;
        logic        mhit;
        logic [1:0]  kk;
        a    = {t, l, w};
        mhit = m_valid[l] && (m_tag[l] == t);
        if (we) begin
            exp_mem_q.push_back('{1'b1, a, wd});
            if (mhit) m_data[l][w] = wd;
            mem_w[a] = wd;
            exp_resp_q.push_back(32'h0);
        end else if (mhit) begin
            m_hits++;
            exp_resp_q.push_back(m_data[l][w]);
        end else begin
            m_misses++;
            for (int k = 0; k < 4; k++) begin
                kk = k[1:0];
                exp_mem_q.push_back('{1'b0, {t, l, kk}, 32'h0});
                m_data[l][kk] = mem_rd({t, l, kk});
            end
            m_tag[l]   = t;
            m_valid[l] = 1'b1;
            exp_resp_q.push_back(m_data[l][w]);
        end
    endfunction

    // Response scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                checks++;
                if (exp_resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got resp_rdata=%h, none expected", resp_rdata);
                end else begin
                    e = exp_resp_q.pop_front();
                    if (resp_rdata !== e) begin
                        errors++;
                        $display("FAIL resp_rdata: got %h expected %h", resp_rdata, e);
                    end
                end
            end
        end
    end

    // Memory model: optional stall, request checking, single-beat read response.
    initial begin
        logic [31:0] a0;
        logic        we0;
        mem_op_t     op;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && mem_req_valid) begin
                a0  = mem_addr;
                we0 = mem_we;
                for (int i = 0; i < mem_stall; i++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (!(mem_req_valid === 1'b1 && mem_addr === a0 && req_ready === 1'b0)) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b addr=%h req_ready=%b expected 1 %h 0",
                                 mem_req_valid, mem_addr, req_ready, a0);
                    end
                end
                mem_req_ready = 1'b1;
                checks++;
                if (exp_mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected: got we=%b addr=%h, none expected", mem_we, mem_addr);
                end else begin
                    op = exp_mem_q.pop_front();
                    if (mem_we !== op.we || mem_addr !== op.addr ||
                        (op.we && mem_wdata !== op.wdata)) begin
                        errors++;
                        $display("FAIL mem_req: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, op.we, op.addr, op.wdata);
                    end
                end
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                if (!we0) begin
                    if (park_k >= 0 && a0[1:0] == park_k[1:0]) begin
                        parked = 1'b1;
                    end else begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = mem_rd(a0);
                        @(posedge clk); #1;
                        mem_resp_valid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic issue(input logic we, input logic [27:0] t, input logic [1:0] l,
                         input logic [1:0] w, input logic [31:0] wd);
        wait_ready();
        predict(we, t, l, w, wd);
        req_valid = 1'b1;
        req_we    = we;
        tag_in    = t;
        lineid_in = l;
        wordid_in = w;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_resp_q.size() != 0 || exp_mem_q.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_resp_q.size() != 0 || exp_mem_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: pending resp=%0d mem=%0d expected 0 0",
                     exp_resp_q.size(), exp_mem_q.size());
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        checks++;
        if (hit_count !== m_hits || miss_count !== m_misses) begin
            errors++;
            $display("FAIL stats: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     hit_count, miss_count, m_hits, m_misses);
        end
    endtask
`endif

    task automatic test_reset();
        logic [3:0]   v;
        logic [111:0] t;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = '0;
        tag_in    = '0;
        lineid_in = '0;
        wordid_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        v = {valid_ctrl[3], valid_ctrl[2], valid_ctrl[1], valid_ctrl[0]};
        t = {tag_ctrl[3], tag_ctrl[2], tag_ctrl[1], tag_ctrl[0]};
        checks++;
        if (v !== 4'h0 || t !== '0) begin
            errors++;
            $display("FAIL reset_arrays: got valid=%b tag=%h expected 0 0", v, t);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || mem_req_valid !== 1'b0 ||
            mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b rd=%h mv=%b we=%b ma=%h wd=%h rdy=%b expected 0 0 0 0 0 0 1",
                     resp_valid, resp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata, req_ready);
        end
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_load_miss();
        issue(1'b0, 28'h0000123, 2'd1, 2'd2, 32'h0);
        checks++;
        if (valid_ctrl[1] !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL refill_valid_low: got valid1=%b req_ready=%b expected 0 0",
                     valid_ctrl[1], req_ready);
        end
        wait_done();
        wait_ready();
        checks++;
        if (valid_ctrl[1] !== 1'b1 || tag_ctrl[1] !== 28'h0000123) begin
            errors++;
            $display("FAIL refill_tag: got valid1=%b tag1=%h expected 1 0000123",
                     valid_ctrl[1], tag_ctrl[1]);
        end
    endtask

    task automatic test_load_hit();
        issue(1'b0, 28'h0000123, 2'd1, 2'd0, 32'h0);
        checks++;
        if (resp_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_latency: got resp_valid=%b mem_req_valid=%b expected 1 0",
                     resp_valid, mem_req_valid);
        end
        wait_done();
    endtask

    task automatic test_store_hit();
        issue(1'b1, 28'h0000123, 2'd1, 2'd3, 32'hDEADBEEF);
        wait_done();
        issue(1'b0, 28'h0000123, 2'd1, 2'd3, 32'h0);
        wait_done();
    endtask

    task automatic test_back_to_back();
        wait_ready();
        for (int w = 0; w < 4; w++) begin
            predict(1'b0, 28'h0000123, 2'd1, w[1:0], 32'h0);
            req_valid = 1'b1;
            req_we    = 1'b0;
            tag_in    = 28'h0000123;
            lineid_in = 2'd1;
            wordid_in = w[1:0];
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: got resp_valid=%b req_ready=%b expected 1 1",
                         w, resp_valid, req_ready);
            end
        end
        req_valid = 1'b0;
        wait_done();
    endtask

    task automatic test_store_miss();
        issue(1'b1, 28'h0000456, 2'd2, 2'd1, 32'h12345678);
        wait_done();
        wait_ready();
        checks++;
        if (valid_ctrl[2] !== 1'b0) begin
            errors++;
            $display("FAIL store_miss_valid: got valid2=%b expected 0", valid_ctrl[2]);
        end
    endtask

    task automatic test_stall();
        mem_stall = 5;
        issue(1'b0, 28'h0000789, 2'd3, 2'd1, 32'h0);
        wait_done();
        mem_stall = 0;
        wait_ready();
        checks++;
        if (valid_ctrl[3] !== 1'b1 || tag_ctrl[3] !== 28'h0000789) begin
            errors++;
            $display("FAIL stall_refill: got valid3=%b tag3=%h expected 1 0000789",
                     valid_ctrl[3], tag_ctrl[3]);
        end
    endtask

    task automatic test_reset_mid();
        int         n = 0;
        logic [3:0] v;
        park_k = 2;
        parked = 1'b0;
        issue(1'b0, 28'h0000ABC, 2'd0, 2'd1, 32'h0);
        while (!parked && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!parked) begin
            errors++;
            $display("FAIL park_timeout: parked=%b expected 1", parked);
        end
        #2;
        rst_n = 1'b0;
        #1;
        v = {valid_ctrl[3], valid_ctrl[2], valid_ctrl[1], valid_ctrl[0]};
        checks++;
        if (mem_req_valid !== 1'b0 || req_ready !== 1'b1 || v !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset: got mv=%b rdy=%b valid=%b expected 0 1 0000",
                     mem_req_valid, req_ready, v);
        end
        model_reset();
        park_k = -1;
        parked = 1'b0;
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(1'b0, 28'h0000ABC, 2'd0, 2'd1, 32'h0);
        wait_done();
        wait_ready();
        checks++;
        if (valid_ctrl[0] !== 1'b1 || tag_ctrl[0] !== 28'h0000ABC) begin
            errors++;
            $display("FAIL recover_refill: got valid0=%b tag0=%h expected 1 0000ABC",
                     valid_ctrl[0], tag_ctrl[0]);
        end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_back_to_back();
        test_store_miss();
        test_stall();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
